// File: rtl/tx_pkg.sv
// Shared types, symbol mapping, saturation and the reference RRC coefficient table
// for the dual-channel IQ pulse shaper.
package tx_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b11
  } level_t;

  typedef enum logic {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } mode_t;

  typedef struct packed {
    level_t i;
    level_t q;
  } lvl_pair_t;

  localparam int SAT_W     = 64;
  localparam int RRC_TAPS  = 33;
  localparam int RRC_WIDTH = 16;

  // Rolloff 0.5, 4 samples/symbol, 8-symbol span, peak scaled to 2^15-1.
  localparam logic signed [15:0] RRC_COEFFS [RRC_TAPS] = '{
    -16'sd291, -16'sd110,  16'sd309,  16'sd474,  16'sd87,   -16'sd474, -16'sd433,
     16'sd446,  16'sd1224, 16'sd446, -16'sd2163, -16'sd4522, -16'sd3059, 16'sd4522,
     16'sd16681, 16'sd28093, 16'sd32767, 16'sd28093, 16'sd16681, 16'sd4522, -16'sd3059,
    -16'sd4522, -16'sd2163, 16'sd446,  16'sd1224, 16'sd446, -16'sd433, -16'sd474,
     16'sd87,    16'sd474,  16'sd309, -16'sd110, -16'sd291
  };

  function automatic lvl_pair_t map_sym(input mode_t mode, input logic [1:0] bits);
    lvl_pair_t p;
    if (mode == MODE_QPSK) begin
      p.i = bits[1] ? NEG : POS;
      p.q = bits[0] ? NEG : POS;
    end else begin
      p.i = bits[0] ? NEG : POS;
      p.q = ZERO;
    end
    return p;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] acc,
                                                  input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (acc > hi) return hi;
    else if (acc < lo) return lo;
    else return acc;
  endfunction

endpackage

// File: rtl/tx_coeff_rom.sv
// Combinational coefficient table shared by the I and Q shapers; taps are packed
// little-end first (tap k at bits [k*COEFF_WIDTH +: COEFF_WIDTH]).
module tx_coeff_rom
  import tx_pkg::*;
#(
  parameter int N           = 33,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_SET   = 0
) (
  output logic [N*COEFF_WIDTH-1:0] coeffs
);

  localparam int CENTER     = (N - 1) / 2;
  localparam int RRC_CENTER = (RRC_TAPS - 1) / 2;
  localparam logic [COEFF_WIDTH-1:0] MAX_C = {1'b0, {(COEFF_WIDTH-1){1'b1}}};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      localparam int SRC = gi - CENTER + RRC_CENTER;
      if (COEFF_SET == 1) begin : g_test
        assign coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = MAX_C;
      end else if (SRC >= 0 && SRC < RRC_TAPS) begin : g_rrc
        // Other tap counts/widths reuse the centre of the reference table, rescaled.
        localparam logic signed [31:0] BASE = {{16{RRC_COEFFS[SRC][15]}}, RRC_COEFFS[SRC]};
        if (COEFF_WIDTH >= RRC_WIDTH) begin : g_up
          assign coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] =
            COEFF_WIDTH'(BASE <<< (COEFF_WIDTH - RRC_WIDTH));
        end else begin : g_dn
          assign coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] =
            COEFF_WIDTH'(BASE >>> (RRC_WIDTH - COEFF_WIDTH));
        end
      end else begin : g_zero
        assign coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/tx_iq_pulse_shaper.sv
// Symbol FIFO, per-symbol BPSK/QPSK mapping, zero-stuffing by SPS and twin
// multiplier-free N-tap FIR shapers producing one saturated I/Q pair per clock.
module tx_iq_pulse_shaper
  import tx_pkg::*;
#(
  parameter int N           = 33,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int SPS         = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int SHIFT       = 15,
  parameter int COEFF_SET   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   trans_in,
  input  logic                         mode_in,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q,
  output logic                         out_valid,
  output logic                         sym_strobe,
  output logic                         underrun
);

  localparam int ACC_W = COEFF_WIDTH + $clog2(N) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PH_W  = $clog2(SPS);

  logic [2:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PH_W-1:0]    r_phase;
  logic               r_seen;
  logic [1:0]         r_strb;
  level_t             r_lvl_i, r_lvl_q;
  level_t             r_tap_i [N];
  level_t             r_tap_q [N];

  logic               w_full, w_empty, w_push, w_pop, w_phase0;
  logic [2:0]         w_rd_entry;
  lvl_pair_t          w_pair;
  logic [N*COEFF_WIDTH-1:0] w_coeffs;
  logic signed [ACC_W-1:0]  w_term_i [N];
  logic signed [ACC_W-1:0]  w_term_q [N];
  logic signed [ACC_W-1:0]  w_acc_i, w_acc_q, w_sh_i, w_sh_q;

  assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_phase0   = (r_phase == '0);
  assign w_push     = sym_valid && !w_full;
  assign w_pop      = w_phase0 && !w_empty;
  assign sym_ready  = !w_full;
  assign w_rd_entry = r_mem[r_rd_ptr];
  assign w_pair     = map_sym(mode_t'(w_rd_entry[2]), w_rd_entry[1:0]);

  always_ff @(posedge clk) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= {mode_in, trans_in};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_phase    <= '0;
      r_seen     <= 1'b0;
      r_strb     <= 2'b00;
      r_lvl_i    <= ZERO;
      r_lvl_q    <= ZERO;
      underrun   <= 1'b0;
      out_valid  <= 1'b0;
      sym_strobe <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_seen   <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_phase <= (r_phase == PH_W'(SPS - 1)) ? '0 : r_phase + 1'b1;
      // Non-zero levels only at a phase-0 pop; every other slot is zero-stuffed.
      r_lvl_i <= w_pop ? w_pair.i : ZERO;
      r_lvl_q <= w_pop ? w_pair.q : ZERO;
      if (w_phase0 && w_empty && r_seen) underrun <= 1'b1;
      r_strb     <= {r_strb[0], w_phase0};
      sym_strobe <= r_strb[1];
      out_valid  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        r_tap_i[k] <= ZERO;
        r_tap_q[k] <= ZERO;
      end
    end else begin
      r_tap_i[0] <= r_lvl_i;
      r_tap_q[0] <= r_lvl_q;
      for (int k = 1; k < N; k++) begin
        r_tap_i[k] <= r_tap_i[k-1];
        r_tap_q[k] <= r_tap_q[k-1];
      end
    end
  end

  tx_coeff_rom #(
    .N           (N),
    .COEFF_WIDTH (COEFF_WIDTH),
    .COEFF_SET   (COEFF_SET)
  ) u_rom (
    .coeffs (w_coeffs)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_term
      logic signed [ACC_W-1:0] w_c;
      assign w_c = {{(ACC_W-COEFF_WIDTH){w_coeffs[gi*COEFF_WIDTH+COEFF_WIDTH-1]}},
                    w_coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH]};
      assign w_term_i[gi] = (r_tap_i[gi] == POS) ? w_c : (r_tap_i[gi] == NEG) ? -w_c : '0;
      assign w_term_q[gi] = (r_tap_q[gi] == POS) ? w_c : (r_tap_q[gi] == NEG) ? -w_c : '0;
    end
  endgenerate

  always_comb begin
    w_acc_i = '0;
    w_acc_q = '0;
    for (int k = 0; k < N; k++) begin
      w_acc_i = w_acc_i + w_term_i[k];
      w_acc_q = w_acc_q + w_term_q[k];
    end
  end

  assign w_sh_i = w_acc_i >>> SHIFT;
  assign w_sh_q = w_acc_q >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_i <= '0;
      out_q <= '0;
    end else begin
      out_i <= DATA_WIDTH'(sat({{(SAT_W-ACC_W){w_sh_i[ACC_W-1]}}, w_sh_i}, DATA_WIDTH));
      out_q <= DATA_WIDTH'(sat({{(SAT_W-ACC_W){w_sh_q[ACC_W-1]}}, w_sh_q}, DATA_WIDTH));
    end
  end

endmodule
